// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU (alu_seq).
// The multiplier is present only when ALU_MUL_EN is defined; otherwise
// opcode MUL decodes as illegal.
package alu_pkg;

    // Widest datapath the sign-extension helper supports.
    localparam int unsigned MaxW = 64;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpAnd  = 3'd2,
        OpAddi = 3'd3,
        OpSll  = 3'd4,
        OpMul  = 3'd5,
        OpOr   = 3'd6,
        OpRsvd = 3'd7
    } op_e;

    localparam op_e OP_ILLEGAL = OpRsvd;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Sign-extend the low imm_w bits of imm to MaxW bits.
    function automatic logic [MaxW-1:0] sext(input logic [MaxW-1:0] imm,
                                             input int unsigned     imm_w);
        logic signed [MaxW-1:0] t;
        t = $signed(imm << (MaxW - imm_w));
        return $unsigned(t >>> (MaxW - imm_w));
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: loads operands on start, then consumes
// one bit of b per cycle for N cycles. done pulses for one cycle once prod
// holds the low N bits of a*b.
module alu_mul_iter #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] prod
);

    localparam int unsigned CntW = $clog2(N + 1);

    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    // Next state: load on start, otherwise one shift-add step while counting.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CntW'(N);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            done_d   = (cnt_q == CntW'(1));
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered N-bit ALU with valid/ready on both sides.
// Define ALU_MUL_EN to build the iterative multiplier (op MUL, latency N+1);
// without it op MUL reports err like the reserved opcode.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned IMM_W = 8,
    parameter int unsigned SH_W  = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    state_e       state_q, state_d;
    logic [N-1:0] result_q, result_d;
    logic         z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;

    logic         accept, is_mul;
    op_e          op_dec;
    logic [N-1:0] imm_ext, op_res;
    logic [N:0]   sum_add, sum_sub, sum_imm;
    logic         op_c, op_v, op_err;
    logic         mul_idle, mul_done;
    logic [N-1:0] mul_prod;

`ifdef ALU_MUL_EN
    logic mul_start, mul_busy;

    alu_mul_iter #(
        .N(N)
    ) u_mul (
        .clk  (clk),
        .rst_n(rst_n),
        .start(mul_start),
        .a    (a),
        .b    (b),
        .busy (mul_busy),
        .done (mul_done),
        .prod (mul_prod)
    );

    assign mul_start = accept & is_mul;
    assign mul_idle  = ~mul_busy;
    assign is_mul    = (op_dec == OpMul);
`else
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
    assign mul_idle  = 1'b1;
    assign is_mul    = 1'b0;
`endif

    // Handshake: a finished result frees the slot in the same cycle it is taken.
    always_comb begin
        in_ready = ((state_q == StIdle) & mul_idle) | ((state_q == StDone) & out_ready);
        accept   = in_valid & in_ready;
    end

    // Single-cycle datapath computed straight from the inputs at accept.
    always_comb begin
        op_dec  = op_e'(op);
        imm_ext = N'(sext(MaxW'(imm), IMM_W));
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} - {1'b0, b};
        sum_imm = {1'b0, a} + {1'b0, imm_ext};
        op_res  = '0;
        op_c    = 1'b0;
        op_v    = 1'b0;
        op_err  = 1'b0;
        unique case (op_dec)
            OpAdd: begin
                op_res = sum_add[N-1:0];
                op_c   = sum_add[N];
                op_v   = (a[N-1] == b[N-1]) & (op_res[N-1] ^ a[N-1]);
            end
            OpSub: begin
                // Bit N of the wide difference is the unsigned borrow.
                op_res = sum_sub[N-1:0];
                op_c   = sum_sub[N];
                op_v   = (a[N-1] ^ b[N-1]) & (op_res[N-1] ^ a[N-1]);
            end
            OpAnd: op_res = a & b;
            OpAddi: begin
                op_res = sum_imm[N-1:0];
                op_c   = sum_imm[N];
                op_v   = (a[N-1] == imm_ext[N-1]) & (op_res[N-1] ^ a[N-1]);
            end
            OpSll: begin
                if (32'(b[SH_W-1:0]) < N) begin
                    op_res = a << b[SH_W-1:0];
                end
            end
            OpOr: op_res = a | b;
            // Reserved opcode, and MUL when the multiplier is not built.
            default: op_err = 1'b1;
        endcase
    end

    // FSM next state and result capture.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = StBusy;
                    end else begin
                        state_d  = StDone;
                        result_d = op_res;
                        z_d      = (op_res == '0);
                        c_d      = op_c;
                        v_d      = op_v;
                        err_d    = op_err;
                    end
                end else if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (mul_done) begin
                    state_d  = StDone;
                    result_d = mul_prod;
                    z_d      = (mul_prod == '0);
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            err_q    <= err_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=16, IMM_W=8): directed cases plus
// randomized traffic against a behavioural model. Honors ALU_MUL_EN.
module tb_alu_seq;

    localparam int N     = 16;
    localparam int IMM_W = 8;
`ifdef ALU_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [7:0]  imm = '0;
    logic        in_ready, out_valid, flag_z, flag_c, flag_v, err;
    logic [15:0] result;

    always #5 clk = ~clk;

    alu_seq #(
        .N    (N),
        .IMM_W(IMM_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .err      (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the opcode definitions, using plain integers.
    function automatic void golden(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                   input logic [7:0] im, output logic [15:0] r,
                                   output bit z, output bit c, output bit v, output bit e);
        int     ux, uy, sx, sy, s, u, amt;
        longint p;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        r = '0; c = 0; v = 0; e = 0; s = 0;
        case (o)
            3'd0: begin u = ux + uy; r = 16'(u); c = (u > 65535); s = sx + sy; end
            3'd1: begin r = 16'(ux - uy); c = (ux < uy); s = sx - sy; end
            3'd2: r = x & y;
            3'd3: begin
                sy = int'($signed(im));
                uy = sy & 32'hFFFF;
                u = ux + uy; r = 16'(u); c = (u > 65535); s = sx + sy;
            end
            3'd4: begin amt = int'(y[4:0]); r = (amt >= 16) ? 16'h0 : 16'(ux << amt); end
            3'd5: begin
                if (MulEn) begin p = longint'(ux) * longint'(uy); r = 16'(p); end
                else e = 1;
            end
            3'd6: r = x | y;
            default: e = 1;
        endcase
        if (o == 3'd0 || o == 3'd1 || o == 3'd3) v = (s > 32767) || (s < -32768);
        z = (r == 16'h0);
    endfunction

    // Model state: expected visible result and remaining multiply latency.
    bit          m_valid = 0;
    int          m_wait = 0;
    bit          m_acc_last = 0;
    logic [15:0] m_res = '0, p_res = '0;
    bit          m_z, m_c, m_v, m_e, p_z, p_e;
    bit          started = 0;

    function automatic bit m_ready();
        return (m_wait == 0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk) begin : model
        bit acc, z, c, v, e;
        logic [15:0] r;
        if (!rst_n) begin
            m_valid = 0; m_wait = 0; m_acc_last = 0;
        end else begin
            acc = in_valid && m_ready();
            m_acc_last = acc;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1; m_res = p_res; m_z = p_z; m_c = 0; m_v = 0; m_e = p_e;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (acc) begin
                golden(op, a, b, imm, r, z, c, v, e);
                if (MulEn && op == 3'd5) begin
                    m_wait = N + 1; m_valid = 0; p_res = r; p_z = z; p_e = e;
                end else begin
                    m_valid = 1; m_res = r; m_z = z; m_c = c; m_v = v; m_e = e;
                end
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started && rst_n) begin
            check("in_ready", in_ready, m_ready());
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("result", result, m_res);
                check("flag_z", flag_z, m_z);
                check("flag_c", flag_c, m_c);
                check("flag_v", flag_v, m_v);
                check("err", err, m_e);
            end
        end
    end

    // Present an op and return just after the edge that accepts it.
    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] im, output int waited);
        op = o; a = x; b = y; imm = im; in_valid = 1'b1;
        waited = 0;
        @(posedge clk); #1;
        while (!m_acc_last && waited < 100) begin
            waited++;
            @(posedge clk); #1;
        end
        if (!m_acc_last) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [15:0] r, input bit z, input bit c,
                       input bit v, input bit e);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_res"}, result, r);
        check({name, "_z"}, flag_z, z);
        check({name, "_c"}, flag_c, c);
        check({name, "_v"}, flag_v, v);
        check({name, "_err"}, err, e);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [4];
        edges[0] = 16'h0000; edges[1] = 16'hFFFF; edges[2] = 16'h7FFF; edges[3] = 16'h8000;
        if ($urandom_range(3) == 0) return edges[$urandom_range(3)];
        return 16'($urandom);
    endfunction

    initial begin
        int w, cyc;
        logic [15:0] held;
        rst_n = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {flag_z, flag_c, flag_v, err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; started = 1;

        issue(3'd0, 16'h7FFF, 16'h0001, 8'h00, w);  lit("add_ovf", 16'h8000, 0, 0, 1, 0);
        issue(3'd1, 16'h0003, 16'h0005, 8'h00, w);  lit("sub_brw", 16'hFFFE, 0, 1, 0, 0);
        issue(3'd3, 16'h0010, 16'h0000, 8'hF0, w);  lit("addi",    16'h0000, 1, 1, 0, 0);
        issue(3'd4, 16'h0001, 16'd15, 8'h00, w);    lit("sll15",   16'h8000, 0, 0, 0, 0);
        issue(3'd4, 16'h0001, 16'd16, 8'h00, w);    lit("sll16",   16'h0000, 1, 0, 0, 0);
        issue(3'd7, 16'h1234, 16'h5678, 8'h00, w);  lit("illegal", 16'h0000, 1, 0, 0, 1);

        // Multiply latency and stall of in_ready.
        issue(3'd5, 16'h0102, 16'h0003, 8'h00, w);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!out_valid) check("mul_in_ready", in_ready, 0);
        end while (!out_valid && cyc < 40);
        if (MulEn) begin
            check("mul_latency", cyc, 17);
            check("mul_result", result, 16'h0306);
        end else begin
            check("mul_latency", cyc, 1);
            check("mul_err", err, 1);
        end

        // Backpressure, then back-to-back accept.
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        issue(3'd0, 16'h1234, 16'h1111, 8'h00, w);
        held = 16'h2345;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_hold", result, held);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(3'd1, 16'h0010, 16'h0001, 8'h00, w);
        check("b2b_wait", w, 0);
        lit("b2b", 16'h000F, 0, 0, 0, 0);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        issue(3'd5, 16'hFFFF, 16'hFFFF, 8'h00, w);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_result", result, 0);
        repeat (30) begin
            @(negedge clk);
            check("mrst_no_stale", out_valid, 0);
        end

        // Randomized traffic with random backpressure.
        @(posedge clk); #1;
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || m_acc_last) begin
                in_valid = ($urandom_range(2) != 0);
                op = 3'($urandom);
                a = pick();
                b = ($urandom_range(3) == 0) ? 16'($urandom_range(20)) : pick();
                imm = 8'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
